midi_poly_player: RTL and testbench
===================================

# midi_poly_player

Polyphonic successor to the single-voice MIDI player. Accepts note-on/note-off commands and allocates them to `VOICES` phase-accumulator oscillators, with voice stealing when all voices are busy. Mixes all voices into one signed sample stream at a fixed sample rate derived from `clk`. Sits between the MIDI front end and the audio output/DAC serializer.

## Interface
- `VOICES`, 4: number of oscillators; power of two, 2..8.
- `SAMPLE_DIV`, 1042: `clk` cycles per output sample (50 MHz / 1042 ≈ 48 kHz).
- `PHASE_W`, 24: phase accumulator width.
- `OUT_W`, 16: output sample width; voice width `VOICE_W = OUT_W - log2(VOICES)`.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `midi_data` in 8: bits [6:0] note number 0..127; bit 7 ignored.
- `midi_note_on` in 1: 1 = note-on, 0 = note-off; qualified by `midi_valid`.
- `midi_valid` in 1: command present.
- `midi_ready` out 1: command accepted when `midi_valid && midi_ready`.
- `wave_sel` in 1: 0 = square, 1 = sawtooth; sampled every tick, applies to all voices.
- `sound_data` out OUT_W: signed mixed sample.
- `sound_valid` out 1: one-cycle strobe per new sample.

## Operation
- Per voice: `active`, `note[6:0]`, `phase[PHASE_W-1:0]`. Global: sample counter, steal pointer `sp` (log2(VOICES) bits).
- Phase increment: 12-entry localparam table `BASE[k]` = round(f(120+k)·2^PHASE_W/48000), f(n) = 440·2^((n-69)/12). `inc(n) = BASE[n%12] >> (10 - n/12)`. BASE[0] = 2926230, BASE[9] = 4921312.
- Note-on, note already active on voice i: retrigger i (phase ← 0); no new allocation.
- Note-on, otherwise: lowest-index inactive voice ← active, note, phase 0. If none free: voice `sp` is stolen (same load), then `sp ← sp+1` (wraps).
- Note-off: every active voice holding that note ← inactive, phase ← 0. Unheld note: ignored.
- Voice sample (VOICE_W bits, signed): inactive → 0. Saw → `{~phase[MSB], phase[MSB-1 -: VOICE_W-1]}`. Square → `phase[MSB] ? -(2^(VOICE_W-1)-1) : +(2^(VOICE_W-1)-1)`.
- Mix: sign-extended sum of all voice samples to OUT_W. Never overflows by construction; no saturation.

## Timing
- Reset: `sound_data` = 0, `sound_valid` = 0, `midi_ready` = 1, all voices inactive, phases 0, counter 0, `sp` = 0. Reset mid-note or mid-command: everything returns to these values; a pending command is dropped.
- Handshake: `midi_ready` = 1 in idle. Acceptance cycle → voice state updated at that edge; `midi_ready` = 0 for exactly the following cycle (allocation settle), then 1. Back-to-back commands therefore take 2 cycles each.
- Sample tick: counter runs 0..SAMPLE_DIV-1; the tick is the cycle where counter = SAMPLE_DIV-1. At the tick edge: `sound_data` ← mix of pre-edge voice state, active phases ← phase + inc (mod 2^PHASE_W), counter ← 0. `sound_valid` = 1 for the cycle immediately after the tick edge, coincident with the new `sound_data`.
- `sound_data` holds between strobes.
- Command accepted on the tick cycle: the mix uses pre-edge state. The command's load/clear of the target voice overrides that voice's phase advance.
- Note-on to first audible sample: ≤ SAMPLE_DIV+1 cycles; the first sample of a (re)triggered voice uses phase 0.

## Test plan
- Reset, no commands, 3 ticks → `sound_valid` pulses exactly every 1042 cycles; `sound_data` = 0 on every pulse; `midi_ready` = 1.
- Note-on 60, saw → voice 0 increment 91444 (±1). Successive samples step by 91444·2^-10 ≈ 89 LSB and wrap from +8191 to −8192 (VOICE_W = 14).
- Note-on 69, square → A4 increment 153791. Output alternates ±8191 with period ≈ 109.09 samples. Note-off 69 → next sample is 0.
- Note-on 60, 62, 64, 65, then 67 → 67 steals voice 0 (`sp` 0→1). Then note-on 69 steals voice 1. Note-off 60 is ignored; note-off 62 has no effect because 62 was already stolen.
- Four square voices in phase (phase MSB = 0) → `sound_data` = 32764, no overflow. Note-on issued on the tick cycle → that sample excludes it; the next sample includes it at phase 0.
- Command accepted → `midi_ready` low exactly 1 cycle. Assert `rst` mid-note → outputs return to reset values within the same cycle; after release, the first strobe arrives after 1042 cycles.

Source files
------------

// File: rtl/midi_poly_player.sv
// midi_poly_player
//   Polyphonic note player: note-on/note-off commands are allocated onto
//   VOICES phase-accumulator oscillators (steal pointer when all are busy).
//   All voices are mixed into one signed sample every SAMPLE_DIV clocks.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   midi_data     [6:0] note number, [7] ignored
//   midi_note_on  1 = note-on, 0 = note-off (qualified by midi_valid)
//   midi_valid    command present
//   midi_ready    command accepted when midi_valid && midi_ready
//   wave_sel      0 = square, 1 = sawtooth, all voices
//   sound_data    signed mixed sample, held between strobes
//   sound_valid   one-cycle strobe per new sample
//
// Handshake states
//   state       | meaning
//   ST_IDLE     | midi_ready high, a command may be accepted
//   ST_SETTLE   | one cycle after an accept, midi_ready low
module midi_poly_player #(
   parameter int VOICES     = 4,
   parameter int SAMPLE_DIV = 1042,
   parameter int PHASE_W    = 24,
   parameter int OUT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       midi_data,
   input  logic             midi_note_on,
   input  logic             midi_valid,
   output logic             midi_ready,
   input  logic             wave_sel,
   output logic [OUT_W-1:0] sound_data,
   output logic             sound_valid
);

   localparam int SP_W    = $clog2(VOICES);
   localparam int VOICE_W = OUT_W - SP_W;
   localparam int CNT_W   = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [VOICE_W-1:0] SQ_POS   = {1'b0, {(VOICE_W-1){1'b1}}};
   localparam logic [VOICE_W-1:0] SQ_NEG   = {1'b1, {(VOICE_W-2){1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [SP_W-1:0]      sp;
   logic [VOICES-1:0]    active;
   logic [6:0]           note  [VOICES];
   logic [PHASE_W-1:0]   phase [VOICES];

   logic [PHASE_W-1:0]   inc_v [VOICES];
   logic [VOICE_W-1:0]   smp   [VOICES];
   logic [OUT_W-1:0]     mix;
   logic [6:0]           cmd_note;
   logic                 accept;
   logic                 tick;
   logic                 hit;
   logic [SP_W-1:0]      hit_idx;
   logic                 free_found;
   logic [SP_W-1:0]      free_idx;
   logic [SP_W-1:0]      tgt;
   logic                 unused_msb;

   assign unused_msb = midi_data[7];
   assign cmd_note   = midi_data[6:0];
   assign accept     = midi_valid && midi_ready;
   assign tick       = (cnt == CNT_LAST);

   // Octave 10 table (notes 120..131), shifted down one bit per octave below.
   function automatic logic [PHASE_W-1:0] note_inc(input logic [6:0] n);
      logic [6:0]  oct;
      logic [6:0]  semi;
      logic [31:0] base;
      oct  = n / 7'd12;
      semi = n % 7'd12;
      case (semi)
         7'd0:    base = 32'd2926230;
         7'd1:    base = 32'd3100232;
         7'd2:    base = 32'd3284582;
         7'd3:    base = 32'd3479893;
         7'd4:    base = 32'd3686818;
         7'd5:    base = 32'd3906048;
         7'd6:    base = 32'd4138314;
         7'd7:    base = 32'd4384391;
         7'd8:    base = 32'd4645100;
         7'd9:    base = 32'd4921312;
         7'd10:   base = 32'd5213948;
         default: base = 32'd5523986;
      endcase
      base = base >> (7'd10 - oct);
      return base[PHASE_W-1:0];
   endfunction

   // Descending scan so the lowest matching / lowest free index wins.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (active[i] && note[i] == cmd_note) begin
            hit     = 1'b1;
            hit_idx = SP_W'(i);
         end
         if (!active[i]) begin
            free_found = 1'b1;
            free_idx   = SP_W'(i);
         end
      end
      tgt = hit ? hit_idx : (free_found ? free_idx : sp);
   end

   // Each voice is VOICE_W bits so the sign-extended sum of VOICES of them
   // always fits OUT_W; no saturation is needed.
   always_comb begin
      mix = '0;
      for (int i = 0; i < VOICES; i++) begin
         smp[i] = '0;
         if (active[i]) begin
            if (wave_sel)
               smp[i] = {~phase[i][PHASE_W-1], phase[i][PHASE_W-2 -: VOICE_W-1]};
            else
               smp[i] = phase[i][PHASE_W-1] ? SQ_NEG : SQ_POS;
         end
         mix      = mix + {{SP_W{smp[i][VOICE_W-1]}}, smp[i]};
         inc_v[i] = note_inc(note[i]);
      end
   end

   // Command writes come after the phase advance so a load/clear on the
   // tick cycle wins over that voice's advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         midi_ready  <= 1'b1;
         cnt         <= '0;
         sp          <= '0;
         active      <= '0;
         sound_data  <= '0;
         sound_valid <= 1'b0;
         for (int i = 0; i < VOICES; i++) begin
            note[i]  <= '0;
            phase[i] <= '0;
         end
      end else begin
         sound_valid <= 1'b0;
         if (tick) begin
            cnt         <= '0;
            sound_valid <= 1'b1;
            sound_data  <= mix;
            for (int i = 0; i < VOICES; i++)
               if (active[i]) phase[i] <= phase[i] + inc_v[i];
         end else begin
            cnt <= cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_SETTLE;
                  midi_ready <= 1'b0;
                  if (midi_note_on) begin
                     active[tgt] <= 1'b1;
                     note[tgt]   <= cmd_note;
                     phase[tgt]  <= '0;
                     if (!hit && !free_found) sp <= sp + 1'b1;
                  end else begin
                     for (int i = 0; i < VOICES; i++) begin
                        if (active[i] && note[i] == cmd_note) begin
                           active[i] <= 1'b0;
                           phase[i]  <= '0;
                        end
                     end
                  end
               end
            end
            default: begin
               state      <= ST_IDLE;
               midi_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_midi_poly_player.sv
module tb_midi_poly_player;

   localparam int VOICES = 4;
   localparam int DIV    = 1042;
   localparam int PW     = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  midi_data = '0;
   logic        midi_note_on = 1'b0;
   logic        midi_valid = 1'b0;
   logic        midi_ready;
   logic        wave_sel = 1'b0;
   logic [15:0] sound_data;
   logic        sound_valid;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   midi_poly_player #(.VOICES(VOICES), .SAMPLE_DIV(DIV), .PHASE_W(PW), .OUT_W(16)) dut (
      .clk(clk), .rst(rst), .midi_data(midi_data), .midi_note_on(midi_note_on),
      .midi_valid(midi_valid), .midi_ready(midi_ready), .wave_sel(wave_sel),
      .sound_data(sound_data), .sound_valid(sound_valid));

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int base_tab[12] = '{2926230, 3100232, 3284582, 3479893, 3686818, 3906048,
                        4138314, 4384391, 4645100, 4921312, 5213948, 5523986};
   bit m_active[VOICES];
   int m_note[VOICES];
   int m_phase[VOICES];
   int m_sp = 0;
   int m_cnt = 0;
   bit m_ready = 1'b1;
   bit m_valid = 1'b0;
   int m_data = 0;

   function automatic int inc_of(input int n);
      return base_tab[n % 12] >> (10 - n / 12);
   endfunction

   function automatic int voice_val(input int p, input bit saw);
      if (saw) return (p >> (PW - 14)) - 8192;
      return (p >= (1 << (PW - 1))) ? -8191 : 8191;
   endfunction

   function automatic int n_active();
      int c = 0;
      for (int i = 0; i < VOICES; i++) if (m_active[i]) c++;
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < VOICES; i++) begin
         m_active[i] = 1'b0; m_note[i] = 0; m_phase[i] = 0;
      end
      m_sp = 0; m_cnt = 0; m_ready = 1'b1; m_valid = 1'b0; m_data = 0;
   endtask

   task automatic model_step();
      bit cmd;
      int n, idx, s;
      cmd = midi_valid && m_ready;
      n   = int'(midi_data[6:0]);
      m_valid = 1'b0;
      if (m_cnt == DIV - 1) begin
         s = 0;
         for (int i = 0; i < VOICES; i++)
            if (m_active[i]) s += voice_val(m_phase[i], wave_sel);
         m_data  = s;
         m_valid = 1'b1;
         m_cnt   = 0;
         for (int i = 0; i < VOICES; i++)
            if (m_active[i]) m_phase[i] = (m_phase[i] + inc_of(m_note[i])) % (1 << PW);
      end else begin
         m_cnt++;
      end
      m_ready = !cmd;
      if (cmd) begin
         if (midi_note_on) begin
            idx = -1;
            for (int i = 0; i < VOICES; i++)
               if (idx < 0 && m_active[i] && m_note[i] == n) idx = i;
            for (int i = 0; i < VOICES; i++)
               if (idx < 0 && !m_active[i]) idx = i;
            if (idx < 0) begin
               idx  = m_sp;
               m_sp = (m_sp + 1) % VOICES;
            end
            m_active[idx] = 1'b1; m_note[idx] = n; m_phase[idx] = 0;
         end else begin
            for (int i = 0; i < VOICES; i++)
               if (m_active[i] && m_note[i] == n) begin
                  m_active[i] = 1'b0; m_phase[i] = 0;
               end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      logic [15:0] exp_d;
      @(negedge clk);
      if (chk_en) begin
         exp_d = 16'(m_data);
         checks++;
         if (midi_ready !== m_ready) begin
            errors++;
            $display("FAIL ready @%0t: got %b want %b", $time, midi_ready, m_ready);
         end
         checks++;
         if (sound_valid !== m_valid) begin
            errors++;
            $display("FAIL valid @%0t: got %b want %b", $time, sound_valid, m_valid);
         end
         checks++;
         if (sound_data !== exp_d) begin
            errors++;
            $display("FAIL data @%0t: got %0d want %0d", $time, $signed(sound_data), $signed(exp_d));
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_strobe(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!sound_valid && cyc < 3 * DIV);
      if (!sound_valid) begin
         checks++; errors++;
         $display("FAIL strobe_timeout: got none want strobe within %0d cycles", 3 * DIV);
      end
   endtask

   task automatic sample_is(input string name, input int exp);
      int c;
      wait_strobe(c);
      chk(name, int'($signed(sound_data)), exp);
   endtask

   task automatic send(input bit on, input int n, input bit now);
      int k;
      if (!now) @(negedge clk);
      midi_valid   = 1'b1;
      midi_note_on = on;
      midi_data    = {~on, 7'(n)};
      k = 0;
      while (!midi_ready && k < 8) begin
         @(negedge clk);
         k++;
      end
      if (!midi_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got ready=0 want ready=1");
      end
      @(negedge clk);
      midi_valid = 1'b0;
      chk("ready_low", int'(midi_ready), 0);
      @(negedge clk);
      chk("ready_back", int'(midi_ready), 1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int c;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      chk("inc60", inc_of(60), 91444);
      chk("inc69", inc_of(69), 153791);

      // idle strobes
      for (int t = 0; t < 3; t++) begin
         wait_strobe(c);
         chk("period", c, DIV);
         chk("idle_data", int'($signed(sound_data)), 0);
      end
      chk("idle_ready", int'(midi_ready), 1);

      // saw note 60
      wave_sel = 1'b1;
      send(1'b1, 60, 1'b0);
      sample_is("saw0", -8192);
      sample_is("saw1", -8103);
      sample_is("saw2", -8014);
      send(1'b0, 60, 1'b0);
      sample_is("saw_off", 0);

      // square note 69
      wave_sel = 1'b0;
      send(1'b1, 69, 1'b0);
      sample_is("sq0", 8191);
      sample_is("sq1", 8191);
      send(1'b0, 69, 1'b0);
      sample_is("sq_off", 0);

      // allocation and stealing
      send(1'b1, 60, 1'b0);
      send(1'b1, 62, 1'b0);
      send(1'b1, 64, 1'b0);
      send(1'b1, 65, 1'b0);
      sample_is("four_sq", 32764);
      send(1'b1, 67, 1'b0);
      chk("steal_v0", m_note[0], 67);
      chk("sp_1", m_sp, 1);
      sample_is("after_steal", 32764);
      send(1'b1, 69, 1'b0);
      chk("steal_v1", m_note[1], 69);
      chk("sp_2", m_sp, 2);
      send(1'b0, 60, 1'b0);
      send(1'b0, 62, 1'b0);
      chk("still_four", n_active(), 4);
      sample_is("four_again", 32764);

      // asynchronous reset mid-note
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_data", int'(sound_data), 0);
      chk("rst_valid", int'(sound_valid), 0);
      chk("rst_ready", int'(midi_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      wait_strobe(c);
      chk("rst_period", c, DIV);
      chk("rst_sample", int'($signed(sound_data)), 0);

      // note-on landing on the tick cycle
      c = 0;
      while (m_cnt != DIV - 1 && c < 2 * DIV) begin
         @(negedge clk);
         c++;
      end
      chk("found_tick", int'(m_cnt == DIV - 1), 1);
      send(1'b1, 60, 1'b1);
      chk("tick_excl", int'($signed(sound_data)), 0);
      sample_is("tick_incl", 8191);

      // polyphonic saw mix
      wave_sel = 1'b1;
      send(1'b1, 72, 1'b0);
      send(1'b1, 48, 1'b0);
      wait_strobe(c);
      wait_strobe(c);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
